// File: rtl/accel_pkg.sv
// Shared accelerator constants and the output-buffer arbiter state type.
package accel_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 512;

  // IDLE: free to grant either requester.
  // WB_HI: second half of an accepted writeback owns the SRAM.
  typedef enum logic {
    IDLE  = 1'b0,
    WB_HI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/output_buffer_arbiter.sv
// Arbiter sharing the single-port output buffer SRAM between the PE-array
// writeback path (1024-bit sums, split into two 512-bit writes) and the host
// read port (single-cycle grant, registered two-cycle read return).
//
// Handshakes: a writeback transfers in the cycle wb_valid && wb_ready; a host
// read transfers in the cycle rd_req && rd_gnt. Grants are combinational from
// state, EN, the requests and the host wait counter, so a requester must hold
// its request/address/data stable until it sees its grant. rd_valid is a
// one-cycle pulse two cycles after rd_gnt and has no back-pressure.
module output_buffer_arbiter
  import accel_pkg::arb_state_t, accel_pkg::IDLE, accel_pkg::WB_HI;
#(
  parameter int ADDR_W   = accel_pkg::ADDR_W,
  parameter int DATA_W   = accel_pkg::DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [2*DATA_W-1:0] wb_data,
  input  logic                rd_req,
  output logic                rd_gnt,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_cen,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_d,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                mem_retn,
  output arb_state_t          o_dbg_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0]   r_hi_addr;
  logic [DATA_W-1:0]   r_hi_data;
  logic                r_rd_pend;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_host_prio;
  logic                w_wb_gnt;
  logic                w_rd_gnt;

  assign w_host_prio = rd_req && (r_wait_cnt >= WAIT_MAX);

  // Arbitration, next state and SRAM port drive; reset masks every grant.
  always_comb begin
    w_state_nxt = r_state;
    w_wb_gnt    = 1'b0;
    w_rd_gnt    = 1'b0;
    mem_cen     = 1'b1;
    mem_wen     = 1'b1;
    mem_addr    = '0;
    mem_d       = '0;
    if (RESET) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (EN) begin
            if (w_host_prio)   w_rd_gnt = 1'b1;
            else if (wb_valid) w_wb_gnt = 1'b1;
            else if (rd_req)   w_rd_gnt = 1'b1;
          end
          if (w_wb_gnt) begin
            w_state_nxt = WB_HI;
            mem_cen     = 1'b0;
            mem_wen     = 1'b0;
            mem_addr    = wb_addr;
            mem_d       = wb_data[DATA_W-1:0];
          end else if (w_rd_gnt) begin
            mem_cen  = 1'b0;
            mem_addr = rd_addr;
          end
        end
        WB_HI: begin
          // The high half always completes, even with EN low.
          w_state_nxt = IDLE;
          mem_cen     = 1'b0;
          mem_wen     = 1'b0;
          mem_addr    = r_hi_addr;
          mem_d       = r_hi_data;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign wb_ready    = w_wb_gnt;
  assign rd_gnt      = w_rd_gnt;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign mem_retn    = 1'b1;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Host starvation counter: counts refused request cycles, saturating.
  always_ff @(posedge CLK) begin
    if (RESET || !rd_req || w_rd_gnt) r_wait_cnt <= '0;
    else if (r_wait_cnt < WAIT_MAX)   r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // Latch the high half and its address (wrapping) when a writeback is taken.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hi_addr <= '0;
      r_hi_data <= '0;
    end else if (w_wb_gnt) begin
      r_hi_addr <= wb_addr + ADDR_W'(1);
      r_hi_data <= wb_data[2*DATA_W-1:DATA_W];
    end
  end

  // Read return: grant -> SRAM access -> capture mem_q -> rd_valid pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= w_rd_gnt;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= mem_q;
    end
  end

endmodule

// File: tb/tb_output_buffer_arbiter.sv
// Bench for output_buffer_arbiter: behavioural SRAM, transaction-level
// reference model, directed scenarios followed by randomized traffic.
module tb_output_buffer_arbiter;
  import accel_pkg::*;

  localparam int MAX_WAIT = 8;
  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  // ---------------- clock / reset / signals ----------------
  logic          CLK = 1'b0;
  logic          RESET, EN, wb_valid, rd_req;
  logic [AW-1:0] wb_addr, rd_addr;
  logic [2*DW-1:0] wb_data;
  logic          wb_ready, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data, mem_d;
  logic [DW-1:0] mem_q = '0;
  logic          mem_cen, mem_wen, mem_retn;
  logic [AW-1:0] mem_addr;
  arb_state_t    dbg_state;

  always #5 CLK = ~CLK;

  output_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_q(mem_q), .mem_retn(mem_retn), .o_dbg_state(dbg_state)
  );

  // Behavioural single-port SRAM: read data appears the cycle after access.
  logic [DW-1:0] sram [int];
  always @(posedge CLK) begin
    if (!mem_cen) begin
      if (!mem_wen) sram[int'(mem_addr)] = mem_d;
      else          mem_q <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : '0;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_known = 0;      // registered outputs defined after first reset edge
  bit            m_hi_pend = 0;    // high half owed to the SRAM this cycle
  logic [AW-1:0] m_hi_addr;
  logic [DW-1:0] m_hi_data;
  int            m_wait = 0;       // cycles the host has been refused
  logic [DW-1:0] ref_mem [int];    // what the SRAM should contain
  logic [DW-1:0] exp_q [$];        // expected read results, oldest first
  int            due_q [$];        // cycle each expected result must appear
  logic [DW-1:0] m_rd_data = '0;
  bit            seen_wb, seen_rd;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // One clock cycle: inputs already applied; check mid-cycle, then advance model.
  task automatic run_cycle();
    bit            e_wb, e_rd, prio, e_rv;
    logic          e_cen, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d;
    #4;
    e_wb = 0; e_rd = 0; e_cen = 1; e_wen = 1; e_addr = '0; e_d = '0;
    if (!RESET) begin
      if (m_hi_pend) begin
        e_cen = 0; e_wen = 0; e_addr = m_hi_addr; e_d = m_hi_data;
      end else if (EN) begin
        prio = rd_req && (m_wait >= MAX_WAIT);
        e_wb = wb_valid && !prio;
        e_rd = rd_req && !e_wb;
        if (e_wb) begin
          e_cen = 0; e_wen = 0; e_addr = wb_addr; e_d = wb_data[DW-1:0];
        end else if (e_rd) begin
          e_cen = 0; e_addr = rd_addr;
        end
      end
    end
    chk("wb_ready", wb_ready, e_wb);
    chk("rd_gnt", rd_gnt, e_rd);
    chk("mem_cen", mem_cen, e_cen);
    chk("mem_wen", mem_wen, e_wen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_d", mem_d, e_d);
    chk("mem_retn", mem_retn, 1'b1);
    if (m_known) begin
      e_rv = (due_q.size() > 0) && (due_q[0] == cyc);
      chk("rd_valid", rd_valid, e_rv);
      if (e_rv) begin
        m_rd_data = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      chk("rd_data", rd_data, m_rd_data);
    end
    seen_wb = wb_ready;
    seen_rd = rd_gnt;
    @(posedge CLK);
    if (RESET) begin
      m_known = 1; m_hi_pend = 0; m_wait = 0; m_rd_data = '0;
      exp_q.delete(); due_q.delete();
    end else begin
      if (!e_cen && !e_wen) ref_mem[int'(e_addr)] = e_d;
      if (e_rd) begin
        exp_q.push_back(ref_read(rd_addr));
        due_q.push_back(cyc + 2);
      end
      m_hi_pend = e_wb;
      if (e_wb) begin
        m_hi_addr = wb_addr + AW'(1);
        m_hi_data = wb_data[2*DW-1:DW];
      end
      if (rd_req && !e_rd) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                 m_wait = 0;
    end
    cyc++;
    #1;
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [2*DW-1:0] rand_wide();
    logic [2*DW-1:0] r;
    for (int i = 0; i < 2*DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    RESET = 0; EN = 1; wb_valid = 0; rd_req = 0;
    wb_addr = '0; rd_addr = '0; wb_data = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] pat_a, pat_5;
  bit   wbf [12];
  int   first_rd, wb_before;

  initial begin
    pat_a = {16{32'hA5A5A5A5}};
    pat_5 = {16{32'h5A5A5A5A}};
    idle_inputs();
    RESET = 1; EN = 0;
    run_cycle();
    run_cycle();
    idle_inputs();
    run_cycle();

    // Single writeback: low at 0x10, high at 0x11.
    wb_valid = 1; wb_addr = 17'h00010; wb_data = {pat_5, pat_a};
    run_cycle();
    wb_valid = 0;
    run_cycle();
    chk("wb1_lo_mem", sram[32'h10], pat_a);
    chk("wb1_hi_mem", sram[32'h11], pat_5);

    // Host read of the high half; result must be held afterwards.
    rd_req = 1; rd_addr = 17'h00011;
    run_cycle();
    rd_req = 0;
    for (int i = 0; i < 4; i++) run_cycle();
    chk("rd1_hold", rd_data, pat_5);

    // Continuous contention from a zero wait count.
    wb_valid = 1; rd_req = 1; rd_addr = 17'h00010; wb_addr = 17'h00040;
    first_rd = -1; wb_before = 0;
    for (int i = 0; i < 12; i++) begin
      wb_data = rand_wide();
      run_cycle();
      wbf[i] = seen_wb;
      if (seen_rd && first_rd < 0) first_rd = i;
      if (seen_wb && first_rd < 0) wb_before++;
    end
    chk("cont_first_rd", first_rd, 8);
    chk("cont_wb_before", wb_before, 4);
    chk("cont_wb_resume", wbf[9], 1'b1);
    idle_inputs();
    for (int i = 0; i < 3; i++) run_cycle();

    // Address wrap on the high half.
    wb_valid = 1; wb_addr = 17'h1FFFF; wb_data = rand_wide();
    run_cycle();
    wb_valid = 0;
    run_cycle();
    chk("wrap_lo_mem", sram[32'h1FFFF], wb_data[DW-1:0]);
    chk("wrap_hi_mem", sram[0], wb_data[2*DW-1:DW]);

    // Reset during WB_HI drops the high half; writeback re-accepted next cycle.
    wb_valid = 1; wb_addr = 17'h00020; wb_data = rand_wide();
    run_cycle();
    RESET = 1;
    run_cycle();
    RESET = 0; wb_addr = 17'h00030; wb_data = rand_wide();
    run_cycle();
    wb_valid = 0;
    run_cycle();

    // Read granted one cycle before reset never returns.
    rd_req = 1; rd_addr = 17'h00030;
    run_cycle();
    rd_req = 0; RESET = 1;
    run_cycle();
    RESET = 0;
    for (int i = 0; i < 3; i++) run_cycle();

    // EN dropped with requests pending; in-flight read still returns.
    rd_req = 1; rd_addr = 17'h00031;
    run_cycle();
    EN = 0; wb_valid = 1; wb_addr = 17'h00050; wb_data = rand_wide();
    for (int i = 0; i < 5; i++) run_cycle();
    EN = 1;
    run_cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) run_cycle();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      RESET    = ($urandom_range(0, 99) < 2);
      EN       = ($urandom_range(0, 9) != 0);
      wb_valid = ($urandom_range(0, 9) < 6);
      rd_req   = ($urandom_range(0, 9) < 5);
      wb_addr  = ($urandom_range(0, 15) == 0) ? 17'h1FFFF : AW'($urandom_range(0, 40));
      rd_addr  = ($urandom_range(0, 15) == 0) ? 17'h1FFFF : AW'($urandom_range(0, 41));
      wb_data  = rand_wide();
      run_cycle();
    end

    idle_inputs();
    for (int i = 0; i < 4; i++) run_cycle();
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
